// File: rtl/octree_cmd_sequencer_pkg.sv
// Shared Octree command types: ctrl/op_done codes and the queued command record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package octree_pkg;

  // 3*TREE_LEVEL + clog2(TREE_LEVEL) with TREE_LEVEL = 4
  localparam int ENCODE_ADDR_WIDTH = 14;

  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'd0,
    CTRL_SEARCH = 2'd1,
    CTRL_ADD    = 2'd2,
    CTRL_DEL    = 2'd3
  } ctrl_e;

  typedef enum logic [1:0] {
    OP_IDLE        = 2'd0,
    OP_SEARCH_DONE = 2'd1,
    OP_ADD_DONE    = 2'd2,
    OP_DEL_DONE    = 2'd3
  } op_done_e;

  typedef struct packed {
    logic [ENCODE_ADDR_WIDTH-1:0] pos_encode;
    ctrl_e                        ctrl;
    logic [3:0]                   tree_num;
  } octree_cmd_t;

endpackage

// File: rtl/octree_cmd_sequencer_if.sv
// Command push channel from the CSR front end into the sequencer queue.
// Latency: n/a (wires only).
// Backpressure: cmd_ready low means the queue is full and cmd_valid is ignored.
interface octree_cmd_sequencer_if
  import octree_pkg::*;
#(
  parameter int EAW = ENCODE_ADDR_WIDTH
);
  logic           cmd_valid;
  logic           cmd_ready;
  logic [EAW-1:0] cmd_pos_encode;
  logic [1:0]     cmd_ctrl;
  logic [3:0]     cmd_tree_num;

  modport master (
    output cmd_valid, cmd_pos_encode, cmd_ctrl, cmd_tree_num,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_pos_encode, cmd_ctrl, cmd_tree_num,
    output cmd_ready
  );
endinterface

// File: rtl/octree_cmd_sequencer_fifo.sv
// Synchronous FIFO of octree_cmd_t; DEPTH must be a power of two (pointers wrap freely).
// Latency: a pushed entry is visible at dout_o the cycle after the push edge.
// Backpressure: full_o blocks pushes (even with a simultaneous pop); pop on empty is ignored.
module octree_cmd_fifo
  import octree_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   push_i,
  input  octree_cmd_t            din_i,
  output logic                   full_o,
  input  logic                   pop_i,
  output octree_cmd_t            dout_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);

  octree_cmd_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is data only, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointers and occupancy; simultaneous push+pop leaves count unchanged.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/octree_cmd_sequencer.sv
// Queues Octree search/add/delete commands and runs them one at a time against the core CSRs.
// Latency: push at cycle 0 into an idle block puts ctrl on the core at cycle 2.
// Backpressure: cmd_ready drops when the queue is full; the core is paced by op_done/received_done.
module octree_cmd_sequencer
  import octree_pkg::*;
#(
  // Must match the package width used by octree_cmd_t.
  parameter int                   ENCODE_ADDR_WIDTH = octree_pkg::ENCODE_ADDR_WIDTH,
  parameter int                   FIFO_DEPTH        = 4,
  parameter int                   TIMEOUT_W         = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES    = 16'hFFFF
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  octree_cmd_sequencer_if.slave         cmd,
  output logic [ENCODE_ADDR_WIDTH-1:0]  core_pos_encode_o,
  output logic [1:0]                    core_ctrl_o,
  output logic [3:0]                    core_tree_num_o,
  input  logic [1:0]                    core_op_done_i,
  output logic                          core_received_done_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic [15:0]                   done_cnt_o,
  output logic [1:0]                    last_done_o,
  output logic                          err_timeout_o,
  output logic                          err_mismatch_o,
  input  logic                          err_clr_i
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] ACK   = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_CYCLES - 1'b1;

  logic [2:0]           state_q;
  octree_cmd_t          cmd_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic                 timed_out_q;
  logic [1:0]           last_done_q;
  logic [15:0]          done_cnt_q;
  logic                 err_timeout_q;
  logic                 err_mismatch_q;

  octree_cmd_t fifo_din;
  octree_cmd_t fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        on_core;
  logic        mismatch_set;
  logic        timeout_set;

  assign fifo_din.pos_encode = cmd.cmd_pos_encode;
  assign fifo_din.ctrl       = ctrl_e'(cmd.cmd_ctrl);
  assign fifo_din.tree_num   = cmd.cmd_tree_num;
  assign cmd.cmd_ready       = !fifo_full;

  // Exactly one entry leaves the queue per IDLE visit (no-ops included).
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  octree_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .push_i  (cmd.cmd_valid),
    .din_i   (fifo_din),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  // ctrl is decoded from state so an async reset removes it from the core at once;
  // pos/tree come straight from cmd_q, which only ever holds issued commands.
  assign on_core              = (state_q == ISSUE) || (state_q == WAIT);
  assign core_ctrl_o          = on_core ? cmd_q.ctrl : 2'd0;
  assign core_pos_encode_o    = cmd_q.pos_encode;
  assign core_tree_num_o      = cmd_q.tree_num;
  assign core_received_done_o = (state_q == ACK);
  assign busy_o               = (state_q != IDLE) || !fifo_empty;
  assign done_cnt_o           = done_cnt_q;
  assign last_done_o          = last_done_q;
  assign err_timeout_o        = err_timeout_q;
  assign err_mismatch_o       = err_mismatch_q;

  assign mismatch_set = (state_q == WAIT) && (core_op_done_i != 2'd0) &&
                        (core_op_done_i != cmd_q.ctrl);
  assign timeout_set  = (state_q == WAIT) && (core_op_done_i == 2'd0) && (wd_q == WD_LAST);

  // Sequencer FSM with command register, watchdog and completion status.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      wd_q        <= '0;
      timed_out_q <= 1'b0;
      last_done_q <= 2'd0;
      done_cnt_q  <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty && (fifo_dout.ctrl != CTRL_IDLE)) begin
            cmd_q   <= fifo_dout;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          wd_q        <= '0;
          timed_out_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (core_op_done_i != 2'd0) begin
            state_q <= ACK;
          end else if (wd_q == WD_LAST) begin
            timed_out_q <= 1'b1;
            state_q     <= ACK;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ACK: begin
          last_done_q <= timed_out_q ? 2'd0 : core_op_done_i;
          if (!timed_out_q) done_cnt_q <= done_cnt_q + 16'd1;
          state_q <= DRAIN;
        end
        DRAIN: begin
          if (core_op_done_i == 2'd0) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error flags; a new event in the same cycle as err_clr_i keeps the flag set.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_timeout_q  <= 1'b0;
      err_mismatch_q <= 1'b0;
    end else begin
      if (timeout_set)    err_timeout_q <= 1'b1;
      else if (err_clr_i) err_timeout_q <= 1'b0;
      if (mismatch_set)   err_mismatch_q <= 1'b1;
      else if (err_clr_i) err_mismatch_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_octree_cmd_sequencer.sv
// Directed bench for octree_cmd_sequencer with a behavioural Octree core model.
// Latency: n/a.
// Backpressure: n/a.
module tb_octree_cmd_sequencer;
  import octree_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [13:0] core_pos_encode_o;
  logic [1:0]  core_ctrl_o;
  logic [3:0]  core_tree_num_o;
  logic [1:0]  core_op_done_i;
  logic        core_received_done_o;
  logic        busy_o;
  logic [2:0]  fifo_count_o;
  logic [15:0] done_cnt_o;
  logic [1:0]  last_done_o;
  logic        err_timeout_o;
  logic        err_mismatch_o;
  logic        err_clr_i;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_done = 0;

  // core model controls: resp_code 0 echoes the issued ctrl
  int       resp_delay = 5;
  logic [1:0] resp_code = 2'd0;
  bit       silent = 1'b0;
  int       mdl_cnt = 0;
  bit       ack_seen = 1'b0;

  // monitor state
  octree_cmd_t issue_log[$];
  int          rd_pulses = 0;
  int          run_len = 0;
  int          last_run = 0;
  logic [1:0]  prev_ctrl = 2'd0;

  always #5 clk_i = ~clk_i;

  octree_cmd_sequencer_if #(.EAW(14)) cmd_if ();

  octree_cmd_sequencer #(
    .ENCODE_ADDR_WIDTH (14),
    .FIFO_DEPTH        (4),
    .TIMEOUT_W         (16),
    .TIMEOUT_CYCLES    (16'd16)
  ) dut (
    .clk_i                (clk_i),
    .rstn_i               (rstn_i),
    .cmd                  (cmd_if),
    .core_pos_encode_o    (core_pos_encode_o),
    .core_ctrl_o          (core_ctrl_o),
    .core_tree_num_o      (core_tree_num_o),
    .core_op_done_i       (core_op_done_i),
    .core_received_done_o (core_received_done_o),
    .busy_o               (busy_o),
    .fifo_count_o         (fifo_count_o),
    .done_cnt_o           (done_cnt_o),
    .last_done_o          (last_done_o),
    .err_timeout_o        (err_timeout_o),
    .err_mismatch_o       (err_mismatch_o),
    .err_clr_i            (err_clr_i)
  );

  // Core model: raise op_done after ctrl has been seen resp_delay times, drop it the cycle after the ack.
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      core_op_done_i = 2'd0;
      mdl_cnt = 0;
      ack_seen = 1'b0;
    end else begin
      if (ack_seen) begin
        core_op_done_i = 2'd0;
        ack_seen = 1'b0;
      end
      if (core_received_done_o) begin
        ack_seen = 1'b1;
        silent = 1'b0;
      end
      if (core_ctrl_o != 2'd0 && core_op_done_i == 2'd0 && !silent) begin
        mdl_cnt++;
        if (mdl_cnt == resp_delay) core_op_done_i = (resp_code == 2'd0) ? core_ctrl_o : resp_code;
      end else if (core_ctrl_o == 2'd0) begin
        mdl_cnt = 0;
      end
    end
  end

  // Monitor: log each issued command, count ack pulses, measure how long ctrl stays up.
  always @(negedge clk_i) begin
    octree_cmd_t ent;
    if (!rstn_i) begin
      prev_ctrl = 2'd0;
      run_len = 0;
    end else begin
      if (core_received_done_o) rd_pulses++;
      if (core_ctrl_o != 2'd0) begin
        if (prev_ctrl == 2'd0) begin
          ent.pos_encode = core_pos_encode_o;
          ent.ctrl       = ctrl_e'(core_ctrl_o);
          ent.tree_num   = core_tree_num_o;
          issue_log.push_back(ent);
        end
        run_len++;
      end else if (prev_ctrl != 2'd0) begin
        last_run = run_len;
        run_len = 0;
      end
      prev_ctrl = core_ctrl_o;
    end
  end

  // Present one command for one cycle; caller is at a negedge and drops valid afterwards.
  task automatic drive(input logic [13:0] pos, input logic [1:0] ctrl, input logic [3:0] tree);
    cmd_if.cmd_valid      = 1'b1;
    cmd_if.cmd_pos_encode = pos;
    cmd_if.cmd_ctrl       = ctrl;
    cmd_if.cmd_tree_num   = tree;
    @(negedge clk_i);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      #1;
      if (!busy_o) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_idle: busy still %0b after %0d cycles, required 0", tag, busy_o, budget);
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_i);
      if (core_received_done_o) begin ok = 1'b1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_ack: no received_done within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    err_clr_i = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_pos_encode = '0;
    cmd_if.cmd_ctrl = '0;
    cmd_if.cmd_tree_num = '0;
    #23;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (cmd_if.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", cmd_if.cmd_ready); end
    n_tests++;
    if ({core_ctrl_o, core_received_done_o, busy_o, fifo_count_o} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_ctl: ctrl=%0d rd=%0b busy=%0b cnt=%0d want all 0", core_ctrl_o, core_received_done_o, busy_o, fifo_count_o);
    end
    n_tests++;
    if ({core_pos_encode_o, core_tree_num_o, done_cnt_o, last_done_o, err_timeout_o, err_mismatch_o} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_status: pos=%h tree=%0d done=%0d last=%0d eto=%0b emm=%0b want all 0",
               core_pos_encode_o, core_tree_num_o, done_cnt_o, last_done_o, err_timeout_o, err_mismatch_o);
    end
  endtask

  task automatic test_single();
    resp_delay = 5;
    resp_code = 2'd0;
    drive(14'h1234, 2'd1, 4'd8);
    cmd_if.cmd_valid = 1'b0;
    n_tests++;
    if (core_ctrl_o !== 2'd0) begin n_fail++; $display("FAIL single_lat1: ctrl=%0d at cycle 1, want 0", core_ctrl_o); end
    @(negedge clk_i);
    n_tests++;
    if (core_ctrl_o !== 2'd1) begin n_fail++; $display("FAIL single_lat2: ctrl=%0d at cycle 2, want 1", core_ctrl_o); end
    wait_idle("single", 50);
    exp_done++;
    n_tests++;
    if (last_run !== 5) begin n_fail++; $display("FAIL single_hold: ctrl held %0d cycles, want 5", last_run); end
    n_tests++;
    if (rd_pulses !== 1) begin n_fail++; $display("FAIL single_pulses: %0d ack pulses, want 1", rd_pulses); end
    n_tests++;
    if (last_done_o !== 2'd1 || done_cnt_o !== 16'(exp_done)) begin
      n_fail++;
      $display("FAIL single_status: last=%0d done=%0d want 1/%0d", last_done_o, done_cnt_o, exp_done);
    end
    n_tests++;
    if (issue_log.size() != 1 || issue_log[0].pos_encode !== 14'h1234 || issue_log[0].tree_num !== 4'd8) begin
      n_fail++;
      $display("FAIL single_issue: log size %0d, want 1 entry pos 1234 tree 8", issue_log.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] pos_t [5] = '{14'h0100, 14'h0201, 14'h0302, 14'h0403, 14'h0504};
    logic [1:0]  ctl_t [5] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd1};
    int log0 = issue_log.size();
    int rd0 = rd_pulses;
    resp_delay = 10;
    drive(pos_t[0], ctl_t[0], 4'd1);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk_i);
    for (int i = 1; i < 5; i++) drive(pos_t[i], ctl_t[i], 4'(i));
    n_tests++;
    if (cmd_if.cmd_ready !== 1'b0 || fifo_count_o !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_full: ready=%0b count=%0d want 0/4", cmd_if.cmd_ready, fifo_count_o);
    end
    drive(14'h3FFF, 2'd3, 4'd15);
    cmd_if.cmd_valid = 1'b0;
    wait_idle("b2b", 300);
    exp_done += 5;
    n_tests++;
    if (issue_log.size() - log0 != 5) begin
      n_fail++;
      $display("FAIL b2b_count: %0d issues, want 5", issue_log.size() - log0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (issue_log[log0+i].pos_encode !== pos_t[i] || issue_log[log0+i].ctrl !== ctl_t[i]) begin
          n_fail++;
          $display("FAIL b2b_order%0d: pos=%h ctrl=%0d want %h/%0d", i,
                   issue_log[log0+i].pos_encode, issue_log[log0+i].ctrl, pos_t[i], ctl_t[i]);
        end
      end
    end
    n_tests++;
    if (done_cnt_o !== 16'(exp_done) || rd_pulses - rd0 != 5 || fifo_count_o !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_status: done=%0d pulses=%0d cnt=%0d want %0d/5/0", done_cnt_o, rd_pulses - rd0, fifo_count_o, exp_done);
    end
  endtask

  task automatic test_timeout();
    resp_delay = 3;
    silent = 1'b1;
    drive(14'h2AAA, 2'd3, 4'd2);
    drive(14'h0555, 2'd1, 4'd4);
    cmd_if.cmd_valid = 1'b0;
    wait_ack("timeout", 60);
    @(negedge clk_i);
    #1;
    n_tests++;
    if (err_timeout_o !== 1'b1 || last_done_o !== 2'd0 || done_cnt_o !== 16'(exp_done)) begin
      n_fail++;
      $display("FAIL timeout_flag: eto=%0b last=%0d done=%0d want 1/0/%0d", err_timeout_o, last_done_o, done_cnt_o, exp_done);
    end
    n_tests++;
    if (last_run !== 17) begin n_fail++; $display("FAIL timeout_len: ctrl held %0d cycles, want 17", last_run); end
    wait_idle("timeout", 60);
    exp_done++;
    n_tests++;
    if (done_cnt_o !== 16'(exp_done) || last_done_o !== 2'd1 || err_timeout_o !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_next: done=%0d last=%0d eto=%0b want %0d/1/1", done_cnt_o, last_done_o, err_timeout_o, exp_done);
    end
  endtask

  task automatic test_mismatch();
    resp_delay = 4;
    resp_code = 2'd3;
    drive(14'h0777, 2'd2, 4'd3);
    cmd_if.cmd_valid = 1'b0;
    wait_idle("mismatch", 60);
    resp_code = 2'd0;
    exp_done++;
    n_tests++;
    if (err_mismatch_o !== 1'b1 || last_done_o !== 2'd3 || done_cnt_o !== 16'(exp_done)) begin
      n_fail++;
      $display("FAIL mismatch_flag: emm=%0b last=%0d done=%0d want 1/3/%0d", err_mismatch_o, last_done_o, done_cnt_o, exp_done);
    end
    @(negedge clk_i);
    err_clr_i = 1'b1;
    @(negedge clk_i);
    err_clr_i = 1'b0;
    n_tests++;
    if (err_mismatch_o !== 1'b0 || err_timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_clr: emm=%0b eto=%0b want 0/0", err_mismatch_o, err_timeout_o);
    end
  endtask

  task automatic test_noop();
    int log0 = issue_log.size();
    resp_delay = 3;
    drive(14'h0011, 2'd1, 4'd5);
    drive(14'h3FFF, 2'd0, 4'd15);
    drive(14'h0022, 2'd3, 4'd6);
    cmd_if.cmd_valid = 1'b0;
    wait_idle("noop", 80);
    exp_done += 2;
    n_tests++;
    if (issue_log.size() - log0 != 2 || done_cnt_o !== 16'(exp_done)) begin
      n_fail++;
      $display("FAIL noop_count: issues=%0d done=%0d want 2/%0d", issue_log.size() - log0, done_cnt_o, exp_done);
    end
    n_tests++;
    if (core_pos_encode_o !== 14'h0022 || core_tree_num_o !== 4'd6 || core_ctrl_o !== 2'd0) begin
      n_fail++;
      $display("FAIL noop_hold: pos=%h tree=%0d ctrl=%0d want 0022/6/0", core_pos_encode_o, core_tree_num_o, core_ctrl_o);
    end
  endtask

  task automatic test_reset_midop();
    int rd0;
    silent = 1'b1;
    drive(14'h0123, 2'd2, 4'd7);
    drive(14'h0124, 2'd1, 4'd7);
    drive(14'h0125, 2'd3, 4'd7);
    cmd_if.cmd_valid = 1'b0;
    n_tests++;
    if (core_ctrl_o !== 2'd2 || fifo_count_o !== 3'd2) begin
      n_fail++;
      $display("FAIL rst_pre: ctrl=%0d cnt=%0d want 2/2", core_ctrl_o, fifo_count_o);
    end
    rd0 = rd_pulses;
    @(posedge clk_i);
    #2;
    rstn_i = 1'b0;
    #1;
    n_tests++;
    if (core_ctrl_o !== 2'd0 || fifo_count_o !== 3'd0 || core_received_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: ctrl=%0d cnt=%0d rd=%0b want 0/0/0", core_ctrl_o, fifo_count_o, core_received_done_o);
    end
    silent = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (rd_pulses != rd0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_nopulse: pulses=%0d busy=%0b want %0d/0", rd_pulses, busy_o, rd0);
    end
    exp_done = 1;
    drive(14'h0456, 2'd1, 4'd9);
    cmd_if.cmd_valid = 1'b0;
    wait_idle("rst_after", 60);
    n_tests++;
    if (done_cnt_o !== 16'(exp_done) || last_done_o !== 2'd1 || core_pos_encode_o !== 14'h0456) begin
      n_fail++;
      $display("FAIL rst_after: done=%0d last=%0d pos=%h want 1/1/0456", done_cnt_o, last_done_o, core_pos_encode_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_mismatch();
    test_noop();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end
endmodule
